// File: rtl/fifo_pkg.sv
// Shared definitions for the asynchronous FIFO write/read controllers:
// default sizing constants and Gray/binary pointer conversion.
package fifo_pkg;

    localparam int DATA_W_DEFAULT = 32;
    localparam int ADDR_W_DEFAULT = 5;
    localparam int GRAY_MAX_W     = 32;

    // Both conversions are width-agnostic for zero-extended operands up to
    // GRAY_MAX_W bits; callers cast in and truncate the result to their width.
    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
        logic [GRAY_MAX_W-1:0] b;
        b = g;
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/ptr_sync.sv
// Multi-flop synchroniser for a Gray-coded pointer crossing into the local
// clock domain; synchronous reset clears every stage.
module ptr_sync #(
    parameter int WIDTH  = 6,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] chain [STAGES];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                chain[i] <= '0;
            end
        end else begin
            chain[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/fifo_wr_ctrl.sv
// Write-domain controller of the asynchronous FIFO: owns the write pointer,
// drives the memory write port and derives full/almost-full/overflow/level.
module fifo_wr_ctrl
    import fifo_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEFAULT,
    parameter int ADDR_W      = ADDR_W_DEFAULT,
    parameter int SYNC_STAGES = 2,
    parameter int OVF_STICKY  = 1
) (
    input  logic              wclk,
    input  logic              sw_rst,
    input  logic [DATA_W-1:0] wdata,
    input  logic              write_enable,
    input  logic [ADDR_W-1:0] afull_value,
    input  logic              overflow_clr,
    input  logic [ADDR_W:0]   rd_ptr_gray,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [ADDR_W:0]   wr_ptr_gray,
    output logic              wfull,
    output logic              wr_almost_ful,
    output logic              overflow,
    output logic [ADDR_W:0]   fifo_write_count,
    output logic [ADDR_W:0]   wr_level
);

    localparam int PTR_W = ADDR_W + 1;

    logic [PTR_W-1:0] wr_bin;
    logic [PTR_W-1:0] wr_bin_next;
    logic [PTR_W-1:0] wr_gray_next;
    logic [PTR_W-1:0] rq_gray;
    logic [PTR_W-1:0] rq_bin;
    logic [PTR_W-1:0] full_gray;
    logic [PTR_W-1:0] level_next;
    logic             accept;
    logic             ovf_event;
    logic             wfull_next;
    logic             afull_next;

    ptr_sync #(
        .WIDTH  (PTR_W),
        .STAGES (SYNC_STAGES)
    ) u_rptr_sync (
        .clk (wclk),
        .rst (sw_rst),
        .d   (rd_ptr_gray),
        .q   (rq_gray)
    );

    assign accept    = write_enable & ~wfull & ~sw_rst;
    assign ovf_event = write_enable & wfull;

    assign mem_we    = accept;
    assign mem_waddr = wr_bin[ADDR_W-1:0];
    assign mem_wdata = wdata;

    assign wr_bin_next  = wr_bin + PTR_W'(accept);
    assign wr_gray_next = PTR_W'(bin2gray(GRAY_MAX_W'(wr_bin_next)));
    assign rq_bin       = PTR_W'(gray2bin(GRAY_MAX_W'(rq_gray)));

    // Full when the write pointer is exactly one lap ahead of the synchronised
    // read pointer: in Gray code that is the top two bits inverted.
    assign full_gray  = {~rq_gray[ADDR_W:ADDR_W-1], rq_gray[ADDR_W-2:0]};
    assign wfull_next = (wr_gray_next == full_gray);
    assign level_next = wr_bin_next - rq_bin;
    assign afull_next = (afull_value != '0) && (level_next >= {1'b0, afull_value});

    always_ff @(posedge wclk) begin
        if (sw_rst) begin
            wr_bin           <= '0;
            wr_ptr_gray      <= '0;
            wfull            <= 1'b0;
            wr_level         <= '0;
            wr_almost_ful    <= 1'b0;
            fifo_write_count <= '0;
            overflow         <= 1'b0;
        end else begin
            wr_bin        <= wr_bin_next;
            wr_ptr_gray   <= wr_gray_next;
            wfull         <= wfull_next;
            wr_level      <= level_next;
            wr_almost_ful <= afull_next;
            if (accept) begin
                fifo_write_count <= fifo_write_count + PTR_W'(1);
            end
            // A new event wins over a simultaneous clear in sticky mode.
            if (OVF_STICKY != 0) begin
                if (ovf_event) begin
                    overflow <= 1'b1;
                end else if (overflow_clr) begin
                    overflow <= 1'b0;
                end
            end else begin
                overflow <= ovf_event;
            end
        end
    end

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Self-checking bench for fifo_wr_ctrl: a default-sized sticky instance (A)
// and a small non-sticky instance (B) checked every cycle against a model.
module tb_fifo_wr_ctrl;

    logic wclk;

    // Instance A: DATA_W=32, ADDR_W=5, sticky overflow
    logic        rst_a, we_a, clr_a;
    logic [31:0] wdata_a;
    logic [4:0]  afv_a;
    int          rd_a;
    logic [5:0]  rd_gray_a;
    logic        mem_we_a, wfull_a, af_a, ovf_a;
    logic [4:0]  mem_waddr_a;
    logic [31:0] mem_wdata_a;
    logic [5:0]  gray_a, cnt_a, lvl_a;

    // Instance B: DATA_W=8, ADDR_W=3, pulsed overflow
    logic        rst_b, we_b, clr_b;
    logic [7:0]  wdata_b;
    logic [2:0]  afv_b;
    int          rd_b;
    logic [3:0]  rd_gray_b;
    logic        mem_we_b, wfull_b, af_b, ovf_b;
    logic [2:0]  mem_waddr_b;
    logic [7:0]  mem_wdata_b;
    logic [3:0]  gray_b, cnt_b, lvl_b;

    int tests_run = 0;
    int tests_failed = 0;
    int stim_cnt = 0;

    // Model state, index 0 = A, 1 = B
    bit m_valid = 0;
    int m_wptr [2];
    int m_cnt  [2];
    int m_lvl  [2];
    int m_sync [2][2];
    bit m_full [2];
    bit m_af   [2];
    bit m_ovf  [2];

    assign rd_gray_a = 6'(rd_a ^ (rd_a >> 1));
    assign rd_gray_b = 4'(rd_b ^ (rd_b >> 1));

    fifo_wr_ctrl #(.DATA_W(32), .ADDR_W(5), .SYNC_STAGES(2), .OVF_STICKY(1)) dut_a (
        .wclk(wclk), .sw_rst(rst_a), .wdata(wdata_a), .write_enable(we_a),
        .afull_value(afv_a), .overflow_clr(clr_a), .rd_ptr_gray(rd_gray_a),
        .mem_we(mem_we_a), .mem_waddr(mem_waddr_a), .mem_wdata(mem_wdata_a),
        .wr_ptr_gray(gray_a), .wfull(wfull_a), .wr_almost_ful(af_a),
        .overflow(ovf_a), .fifo_write_count(cnt_a), .wr_level(lvl_a)
    );

    fifo_wr_ctrl #(.DATA_W(8), .ADDR_W(3), .SYNC_STAGES(2), .OVF_STICKY(0)) dut_b (
        .wclk(wclk), .sw_rst(rst_b), .wdata(wdata_b), .write_enable(we_b),
        .afull_value(afv_b), .overflow_clr(clr_b), .rd_ptr_gray(rd_gray_b),
        .mem_we(mem_we_b), .mem_waddr(mem_waddr_b), .mem_wdata(mem_wdata_b),
        .wr_ptr_gray(gray_b), .wfull(wfull_b), .wr_almost_ful(af_b),
        .overflow(ovf_b), .fifo_write_count(cnt_b), .wr_level(lvl_b)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    task automatic checkOutput(input string name, input longint act, input longint exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Occupancy-level model: the FIFO is full when level equals depth, and the
    // read pointer seen by the write side lags the driven one by two edges.
    task automatic modelStep(input int d, input bit rst, input bit we, input bit clr,
                             input int afv, input int rd);
        int dep, modv, rq;
        bit acc, evt;
        dep  = (d == 0) ? 32 : 8;
        modv = 2 * dep;
        if (rst) begin
            m_wptr[d] = 0; m_cnt[d] = 0; m_lvl[d] = 0;
            m_sync[d][0] = 0; m_sync[d][1] = 0;
            m_full[d] = 0; m_af[d] = 0; m_ovf[d] = 0;
            m_valid = 1;
        end else begin
            acc = we && !m_full[d];
            evt = we && m_full[d];
            rq  = m_sync[d][1];
            m_sync[d][1] = m_sync[d][0];
            m_sync[d][0] = rd;
            m_wptr[d] = (m_wptr[d] + int'(acc)) % modv;
            m_cnt[d]  = (m_cnt[d] + int'(acc)) % modv;
            m_lvl[d]  = (m_wptr[d] - rq + modv) % modv;
            m_full[d] = (m_lvl[d] == dep);
            m_af[d]   = (afv != 0) && (m_lvl[d] >= afv);
            m_ovf[d]  = (d == 0) ? (evt || (m_ovf[d] && !clr)) : evt;
        end
    endtask

    always @(posedge wclk) begin
        modelStep(0, rst_a, we_a, clr_a, int'(afv_a), rd_a);
        modelStep(1, rst_b, we_b, clr_b, int'(afv_b), rd_b);
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge wclk) begin
        if (m_valid) begin
            checkOutput("A.mem_we", mem_we_a, we_a && !m_full[0] && !rst_a);
            checkOutput("A.mem_waddr", mem_waddr_a, m_wptr[0] % 32);
            checkOutput("A.mem_wdata", mem_wdata_a, wdata_a);
            checkOutput("A.wr_ptr_gray", gray_a, m_wptr[0] ^ (m_wptr[0] >> 1));
            checkOutput("A.wfull", wfull_a, m_full[0]);
            checkOutput("A.almost_full", af_a, m_af[0]);
            checkOutput("A.overflow", ovf_a, m_ovf[0]);
            checkOutput("A.write_count", cnt_a, m_cnt[0]);
            checkOutput("A.wr_level", lvl_a, m_lvl[0]);
            checkOutput("B.mem_we", mem_we_b, we_b && !m_full[1] && !rst_b);
            checkOutput("B.mem_waddr", mem_waddr_b, m_wptr[1] % 8);
            checkOutput("B.mem_wdata", mem_wdata_b, wdata_b);
            checkOutput("B.wr_ptr_gray", gray_b, m_wptr[1] ^ (m_wptr[1] >> 1));
            checkOutput("B.wfull", wfull_b, m_full[1]);
            checkOutput("B.almost_full", af_b, m_af[1]);
            checkOutput("B.overflow", ovf_b, m_ovf[1]);
            checkOutput("B.write_count", cnt_b, m_cnt[1]);
            checkOutput("B.wr_level", lvl_b, m_lvl[1]);
        end
    end

    // Hold the given controls for n edges, fresh data each cycle
    task automatic applyStimulus(input int d, input bit we, input bit clr, input int n);
        for (int i = 0; i < n; i++) begin
            stim_cnt++;
            if (d == 0) begin
                we_a = we; clr_a = clr; wdata_a = 32'hC0DE_0000 | 32'(stim_cnt);
            end else begin
                we_b = we; clr_b = clr; wdata_b = 8'(stim_cnt * 7);
            end
            @(posedge wclk);
            #1;
        end
    endtask

    task automatic doReset(input int d);
        if (d == 0) rst_a = 1'b1; else rst_b = 1'b1;
        applyStimulus(d, 1'b0, 1'b0, 2);
        if (d == 0) rst_a = 1'b0; else rst_b = 1'b0;
    endtask

    initial begin
        rst_a = 1; we_a = 0; clr_a = 0; wdata_a = '0; afv_a = '0; rd_a = 0;
        rst_b = 1; we_b = 0; clr_b = 0; wdata_b = '0; afv_b = '0; rd_b = 0;

        // A: reset, then fill to full with almost-full disabled
        doReset(0);
        checkOutput("A.reset_level", lvl_a, 0);
        checkOutput("A.reset_gray", gray_a, 0);
        checkOutput("A.reset_full", wfull_a, 0);
        applyStimulus(0, 1, 0, 32);
        checkOutput("A.full_after_32", wfull_a, 1);
        checkOutput("A.level_32", lvl_a, 32);
        checkOutput("A.count_32", cnt_a, 32);
        checkOutput("A.af_disabled", af_a, 0);
        we_a = 1;
        #1;
        checkOutput("A.mem_we_when_full", mem_we_a, 0);
        @(posedge wclk);
        #1;
        checkOutput("A.overflow_set", ovf_a, 1);
        checkOutput("A.count_after_drop", cnt_a, 32);
        applyStimulus(0, 0, 0, 2);
        checkOutput("A.overflow_sticky", ovf_a, 1);
        applyStimulus(0, 1, 1, 1);
        checkOutput("A.overflow_clr_vs_event", ovf_a, 1);
        applyStimulus(0, 0, 1, 1);
        checkOutput("A.overflow_cleared", ovf_a, 0);
        rd_a = 4;
        applyStimulus(0, 0, 0, 2);
        checkOutput("A.full_clears_late", wfull_a, 1);
        applyStimulus(0, 0, 0, 1);
        checkOutput("A.full_cleared", wfull_a, 0);
        checkOutput("A.level_28", lvl_a, 28);

        // A: almost-full at 28, falling once the read pointer reaches 4
        rd_a = 0;
        doReset(0);
        afv_a = 5'd28;
        applyStimulus(0, 1, 0, 27);
        checkOutput("A.af_below", af_a, 0);
        applyStimulus(0, 1, 0, 1);
        checkOutput("A.af_at_28", af_a, 1);
        rd_a = 4;
        applyStimulus(0, 0, 0, 2);
        checkOutput("A.af_still_2_edges", af_a, 1);
        applyStimulus(0, 0, 0, 1);
        checkOutput("A.af_falls_3_edges", af_a, 0);
        checkOutput("A.level_24", lvl_a, 24);
        afv_a = '0;

        // A: 70 writes with a reader trailing by 5, wrapping the pointer
        rd_a = 0;
        doReset(0);
        for (int i = 0; i < 70; i++) begin
            rd_a = (i >= 5) ? i - 5 : 0;
            applyStimulus(0, 1, 0, 1);
        end
        checkOutput("A.count_wrap_6", cnt_a, 6);
        checkOutput("A.gray_after_wrap", gray_a, 5);

        // A: reset mid-burst at level 17 with write_enable held
        rd_a = 0;
        doReset(0);
        applyStimulus(0, 1, 0, 17);
        checkOutput("A.level_17", lvl_a, 17);
        rst_a = 1;
        we_a = 1;
        #1;
        checkOutput("A.mem_we_in_reset", mem_we_a, 0);
        @(posedge wclk);
        #1;
        checkOutput("A.rst_level", lvl_a, 0);
        checkOutput("A.rst_count", cnt_a, 0);
        checkOutput("A.rst_gray", gray_a, 0);
        rst_a = 0;
        applyStimulus(0, 0, 0, 1);

        // B: small FIFO, almost-full at 6, single-cycle overflow pulses
        doReset(1);
        afv_b = 3'd6;
        applyStimulus(1, 1, 0, 5);
        checkOutput("B.af_below", af_b, 0);
        applyStimulus(1, 1, 0, 1);
        checkOutput("B.af_at_6", af_b, 1);
        applyStimulus(1, 1, 0, 2);
        checkOutput("B.full_after_8", wfull_b, 1);
        checkOutput("B.level_8", lvl_b, 8);
        checkOutput("B.no_overflow_yet", ovf_b, 0);
        applyStimulus(1, 1, 0, 1);
        checkOutput("B.ovf_pulse_1", ovf_b, 1);
        applyStimulus(1, 0, 0, 1);
        checkOutput("B.ovf_drops", ovf_b, 0);
        applyStimulus(1, 1, 0, 1);
        checkOutput("B.ovf_pulse_2", ovf_b, 1);
        applyStimulus(1, 0, 0, 1);
        checkOutput("B.ovf_drops_2", ovf_b, 0);
        checkOutput("B.count_8", cnt_b, 8);

        applyStimulus(1, 0, 0, 2);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
